// File: rtl/desired_drive_pipe_if.sv
// Sample/result bundle between the assist-path front end and the desired-drive pipeline.
// The master drives samples and receives target current; the slave is the pipeline.
interface desired_drive_pipe_if #(
    parameter int TORQ_W = 12,
    parameter int INCL_W = 13,
    parameter int CAD_W  = 5,
    parameter int SET_W  = 2,
    parameter int CURR_W = 12
);
    logic                     in_vld;
    logic [TORQ_W-1:0]        avg_torque;
    logic [CAD_W-1:0]         cadence_vec;
    logic signed [INCL_W-1:0] incline;
    logic [SET_W-1:0]         setting;
    logic [CURR_W-1:0]        target_curr;
    logic                     out_vld;

    modport master (
        output in_vld, avg_torque, cadence_vec, incline, setting,
        input  target_curr, out_vld
    );

    modport slave (
        input  in_vld, avg_torque, cadence_vec, incline, setting,
        output target_curr, out_vld
    );
endinterface

// File: rtl/desired_drive_pipe.sv
// Pipelined desired-drive calculator: capture, factor, product, scale/saturate, output (latency 4).
// Define SLEW_LIMIT_EN to bound the per-sample change of target_curr by SLEW_STEP.
module desired_drive_pipe #(
    parameter int                TORQ_W     = 12,
    parameter int                INCL_W     = 13,
    parameter int                CAD_W      = 5,
    parameter int                SET_W      = 2,
    parameter int                CURR_W     = 12,
    parameter logic [TORQ_W-1:0] TORQUE_MIN = 12'h380,
    parameter int                CAD_OFF    = 32,
    parameter int                SHIFT      = 14,
    parameter logic [CURR_W-1:0] SLEW_STEP  = 12'h100
) (
    input  logic                clk,
    input  logic                rst,
    desired_drive_pipe_if.slave bus
);
    localparam int PA_W = TORQ_W + 9;
    localparam int CF_W = CAD_W + 1;
    localparam int PB_W = CF_W + SET_W;
    localparam int PW   = PA_W + PB_W;

    localparam logic signed [INCL_W-1:0] INCL_HI = INCL_W'(511);
    localparam logic signed [INCL_W-1:0] INCL_LO = INCL_W'(-512);

    // Capture stage: raw sample registers
    logic                     vld0_q, vld0_d;
    logic [TORQ_W-1:0]        torq0_q, torq0_d;
    logic [CAD_W-1:0]         cad0_q, cad0_d;
    logic signed [INCL_W-1:0] incl0_q, incl0_d;
    logic [SET_W-1:0]         set0_q, set0_d;

    // S1: conditioned factors
    logic                     vld1_q, vld1_d;
    logic [TORQ_W-1:0]        torq1_q, torq1_d;
    logic [8:0]               incl1_q, incl1_d;
    logic [CF_W-1:0]          cad1_q, cad1_d;
    logic [SET_W-1:0]         set1_q, set1_d;

    // S2: partial products
    logic                     vld2_q, vld2_d;
    logic [PA_W-1:0]          prod_a_q, prod_a_d;
    logic [PB_W-1:0]          prod_b_q, prod_b_d;

    // S3: scaled, saturated current
    logic                     vld3_q, vld3_d;
    logic [CURR_W-1:0]        raw3_q, raw3_d;

    // S4: output
    logic                     out_vld_q, out_vld_d;
    logic [CURR_W-1:0]        curr_q, curr_d;

    logic signed [9:0]        incl_sat;
    logic signed [10:0]       incl_sum;
    logic [PW-1:0]            prod;
    logic [PW-1:0]            prod_shr;
    logic [CURR_W-1:0]        delta;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        vld0_d    = bus.in_vld;
        torq0_d   = bus.avg_torque;
        cad0_d    = bus.cadence_vec;
        incl0_d   = bus.incline;
        set0_d    = bus.setting;

        torq1_d   = (torq0_q > TORQUE_MIN) ? torq0_q - TORQUE_MIN : '0;
        if (incl0_q > INCL_HI)      incl_sat = 10'sd511;
        else if (incl0_q < INCL_LO) incl_sat = -10'sd512;
        else                        incl_sat = incl0_q[9:0];
        // Sum spans [-256, 767]: bit 10 flags negative, bit 9 flags above 511.
        incl_sum  = {incl_sat[9], incl_sat} + 11'sd256;
        if (incl_sum[10])     incl1_d = '0;
        else if (incl_sum[9]) incl1_d = 9'd511;
        else                  incl1_d = incl_sum[8:0];
        cad1_d    = (cad0_q > CAD_W'(1)) ? CF_W'(cad0_q) + CF_W'(CAD_OFF) : '0;
        set1_d    = set0_q;
        vld1_d    = vld0_q;

        prod_a_d  = PA_W'(torq1_q) * PA_W'(incl1_q);
        prod_b_d  = PB_W'(cad1_q) * PB_W'(set1_q);
        vld2_d    = vld1_q;

        prod      = PW'(prod_a_q) * PW'(prod_b_q);
        prod_shr  = prod >> SHIFT;
        raw3_d    = ((prod_shr >> CURR_W) != '0) ? '1 : prod_shr[CURR_W-1:0];
        vld3_d    = vld2_q;

        out_vld_d = vld3_q;
        curr_d    = curr_q;
        delta     = '0;
        if (vld3_q) begin
`ifdef SLEW_LIMIT_EN
            if (raw3_q > curr_q) begin
                delta  = raw3_q - curr_q;
                curr_d = curr_q + ((delta > SLEW_STEP) ? SLEW_STEP : delta);
            end else begin
                delta  = curr_q - raw3_q;
                curr_d = curr_q - ((delta > SLEW_STEP) ? SLEW_STEP : delta);
            end
`else
            curr_d = raw3_q;
`endif
        end
    end

    // NOTE: state updates use non-blocking assignments so every stage samples its predecessor's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are cleared too, not just valids, so target_curr and all stages read zero after reset.
            vld0_q    <= 1'b0;
            torq0_q   <= '0;
            cad0_q    <= '0;
            incl0_q   <= '0;
            set0_q    <= '0;
            vld1_q    <= 1'b0;
            torq1_q   <= '0;
            incl1_q   <= '0;
            cad1_q    <= '0;
            set1_q    <= '0;
            vld2_q    <= 1'b0;
            prod_a_q  <= '0;
            prod_b_q  <= '0;
            vld3_q    <= 1'b0;
            raw3_q    <= '0;
            out_vld_q <= 1'b0;
            curr_q    <= '0;
        end else begin
            vld0_q    <= vld0_d;
            torq0_q   <= torq0_d;
            cad0_q    <= cad0_d;
            incl0_q   <= incl0_d;
            set0_q    <= set0_d;
            vld1_q    <= vld1_d;
            torq1_q   <= torq1_d;
            incl1_q   <= incl1_d;
            cad1_q    <= cad1_d;
            set1_q    <= set1_d;
            vld2_q    <= vld2_d;
            prod_a_q  <= prod_a_d;
            prod_b_q  <= prod_b_d;
            vld3_q    <= vld3_d;
            raw3_q    <= raw3_d;
            out_vld_q <= out_vld_d;
            curr_q    <= curr_d;
        end
    end

    assign bus.target_curr = curr_q;
    assign bus.out_vld     = out_vld_q;

endmodule

// File: tb/tb_desired_drive_pipe.sv
// Scoreboard bench for desired_drive_pipe: directed vectors with hand-computed raw currents,
// expected results queued at issue time and checked by a separate output monitor.
module tb_desired_drive_pipe;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    desired_drive_pipe_if bus ();

    desired_drive_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [11:0] torq;
        logic [4:0]  cad;
        logic [12:0] incl;
        logic [1:0]  set;
        logic [11:0] raw;
    } vec_t;

    typedef struct {
        logic [11:0] val;
        int          due;
    } exp_t;

    vec_t        vecs[6];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_bad    = 0;
    logic [11:0] model_curr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected target_curr after one sample with the given raw value.
    function automatic logic [11:0] model_step(input logic [11:0] cur, input logic [11:0] raw);
`ifdef SLEW_LIMIT_EN
        logic [11:0] d;
        if (raw > cur) begin
            d = raw - cur;
            return cur + ((d > 12'h100) ? 12'h100 : d);
        end
        d = cur - raw;
        return cur - ((d > 12'h100) ? 12'h100 : d);
`else
        return (cur == cur) ? raw : raw;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_vld", 32'(bus.out_vld), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("target_curr", 32'(bus.target_curr), 32'(e.val));
                check("latency", cyc, e.due);
            end
        end
    end

    // Called right after a negedge; returns after the following negedge.
    task automatic send(input vec_t v);
        exp_t e;
        bus.in_vld      = 1'b1;
        bus.avg_torque  = v.torq;
        bus.cadence_vec = v.cad;
        bus.incline     = v.incl;
        bus.setting     = v.set;
        model_curr      = model_step(model_curr, v.raw);
        e.val           = model_curr;
        e.due           = cyc + 5;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int budget = 40;
        bus.in_vld = 1'b0;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain", exp_q.size(), 0);
        idle(2);
        check("hold", 32'(bus.target_curr), 32'(model_curr));
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{12'h800, 5'h10, 13'h0150, 2'd2, 12'hD79};
        vecs[1] = '{12'h800, 5'h10, 13'h1F22, 2'd3, 12'h158};
        vecs[2] = '{12'h360, 5'h10, 13'h00C0, 2'd3, 12'h000};
        vecs[3] = '{12'h800, 5'h18, 13'h1EF0, 2'd3, 12'h000};
        vecs[4] = '{12'h7E0, 5'h18, 13'h0000, 2'd3, 12'hB7C};
        vecs[5] = '{12'h7E0, 5'h18, 13'h0080, 2'd3, 12'hFFF};

        rst             = 1'b1;
        bus.in_vld      = 1'b0;
        bus.avg_torque  = '0;
        bus.cadence_vec = '0;
        bus.incline     = '0;
        bus.setting     = '0;
        repeat (3) @(negedge clk);
        check("reset_curr", 32'(bus.target_curr), 32'd0);
        check("reset_vld", 32'(bus.out_vld), 32'd0);
        rst = 1'b0;
        idle(2);

        // Isolated samples
        for (int i = 0; i < 6; i++) begin
            send(vecs[i]);
            drain();
        end

        // Back-to-back burst, then a 3-cycle bubble
        for (int i = 0; i < 6; i++) send(vecs[i]);
        idle(3);
        for (int i = 0; i < 3; i++) send(vecs[i]);
        drain();

        // Reset two cycles after the sample is captured discards it
        send(vecs[4]);
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        model_curr = '0;
        rst        = 1'b0;
        check("rst_flush_curr", 32'(bus.target_curr), 32'd0);
        check("rst_flush_vld", 32'(bus.out_vld), 32'd0);
        idle(8);
        check("post_rst_curr", 32'(bus.target_curr), 32'd0);

`ifdef SLEW_LIMIT_EN
        for (int i = 0; i < 14; i++) send(vecs[0]);
        drain();
        check("slew_up_final", 32'(bus.target_curr), 32'hD79);
        v     = vecs[0];
        v.set = 2'd0;
        v.raw = 12'h000;
        for (int i = 0; i < 14; i++) send(v);
        drain();
        check("slew_down_final", 32'(bus.target_curr), 32'h000);
`else
        v = vecs[5];
        send(v);
        v.set = 2'd0;
        v.raw = 12'h000;
        send(v);
        drain();
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/desired_drive_pipe.md
Name: desired_drive_pipe

Overview:
Pipelined, parametrised successor to the combinational desired-drive calculator in the e-bike assist path. It accepts samples of avg_torque, cadence_vec, incline and setting with a valid strobe, and computes the motor target current over registered stages with saturation. It emits target_curr with a one-cycle out_vld pulse to the PID/inertial logic downstream. An optional slew limiter bounds the change in target_curr per sample.

Parameters:
TORQ_W, 12, avg_torque width (unsigned)
INCL_W, 13, incline width (signed two's complement), >= 10
CAD_W, 5, cadence_vec width (unsigned)
SET_W, 2, setting width (unsigned assist level)
CURR_W, 12, target_curr width
TORQUE_MIN, 12'h380, torque dead-band subtracted from avg_torque
CAD_OFF, 32, offset added to cadence when cadence_vec > 1
SHIFT, 14, right shift applied to final product
SLEW_STEP, 12'h100, max |delta target_curr| per valid sample (SLEW_LIMIT_EN only)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active high
in_vld  in  1  sample strobe; inputs captured on the cycle it is high
avg_torque  in  TORQ_W  filtered pedal torque
cadence_vec  in  CAD_W  cadence
incline  in  INCL_W  signed incline
setting  in  SET_W  assist level, 0 = off
target_curr  out  CURR_W  registered target motor current
out_vld  out  1  one-cycle pulse: target_curr updated this cycle

Behaviour:
- One clock, synchronous active-high reset (clk, rst). On rst: all stage valids 0, all stage registers 0, target_curr = 0, out_vld = 0. Reset mid-pipeline discards in-flight samples, with no out_vld for them.
- Fully pipelined, no backpressure: accepts in_vld every cycle. Fixed latency 4: sample captured at edge N gives out_vld high in the cycle after edge N+4. Bubbles propagate as bubbles.
- S1 (capture):
  - torque_pos = avg_torque > TORQUE_MIN ? avg_torque - TORQUE_MIN : 0.
  - incline_sat = incline clamped to signed 10-bit [-512, 511].
  - incl_fac = incline_sat + 256, clamped to [0, 511] (9 bits).
  - cad_fac = cadence_vec > 1 ? cadence_vec + CAD_OFF : 0 (CAD_W+1 bits).
  - Register setting.
- S2: prod_a = torque_pos * incl_fac; prod_b = cad_fac * setting. Both are full-width unsigned.
- S3: prod = prod_a * prod_b, with width PW = TORQ_W+9+CAD_W+1+SET_W (29 by default).
  - raw = (prod >> SHIFT) truncated to CURR_W bits.
  - If any prod bit at or above SHIFT+CURR_W is set, raw = all ones.
- S4: target_curr <= raw (or the slew-limited value) and out_vld <= 1. target_curr holds between pulses.
- Zero cases give raw = 0: torque at or below TORQUE_MIN, setting = 0, cadence_vec <= 1, or incline at or below -256.

Optional Feature:
SLEW_LIMIT_EN.
- Defined: at S4, if raw > target_curr then target_curr += min(SLEW_STEP, raw - target_curr). Otherwise target_curr -= min(SLEW_STEP, target_curr - raw). There is no overshoot or wrap. Latency is unchanged. Reset returns target_curr to 0.
- Undefined: target_curr = raw on every valid sample.

Test Plan:
- Undefined macro; avg_torque=800, cadence_vec=10, incline=0150, setting=2 (hex), single in_vld -> out_vld exactly 4 cycles later, target_curr=D79. Then incline=1F22, setting=3 -> 158.
- avg_torque=360 (below TORQUE_MIN), incline=0C0 -> 000. Then avg_torque=800, cadence_vec=18, incline=1EF0 -> 000 (incline clamp to 0).
- avg_torque=7E0, cadence_vec=18, setting=3: incline=0000 -> B7C; incline=0080 -> FFF (saturation).
- in_vld high 6 consecutive cycles with the vectors above -> 6 back-to-back out_vld pulses, results in order. Then a 3-cycle in_vld gap -> 3-cycle out_vld gap.
- Assert rst for 1 cycle 2 cycles after in_vld -> no out_vld for that sample; target_curr=000, out_vld=0 next cycle.
- Defined SLEW_LIMIT_EN; repeat the D79 vector -> target_curr 100, 200, ... D00, D79 (14 pulses). Then setting=0 -> decrements by 100 to 079, then 000.
